// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - shares the SDRAM controller port between the game loader and the NES core
module sdram_port_arbiter #(
  parameter int ADDR_W     = 22,
  parameter int FIFO_DEPTH = 4,
  parameter int SLOT_PHASE = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [1:0]        ce_phase,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  input  logic              ld_done,
  input  logic [ADDR_W-1:0] nes_addr,
  input  logic              nes_rd_cpu,
  input  logic              nes_rd_ppu,
  input  logic              nes_wr,
  input  logic [7:0]        nes_dout,
  output logic [24:0]       mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_din,
  output logic              mem_oe_a,
  output logic              mem_oe_b,
  output logic              sd_drive,
  output logic              nes_reset,
  output logic              fifo_full,
  output logic              overflow,
  output logic [1:0]        state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] SLOT = 2'(SLOT_PHASE);
  localparam logic [PW:0] CNT_FULL = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [7:0]        fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_idx;
  logic [PW:0]       count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              done_q;
  logic              wr_active_q, wr_active_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              slot, full, empty, done_fall, flush, push, pop, run;

  assign slot      = (ce_phase == SLOT);
  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign done_fall = done_q & ~ld_done;
  assign run       = (state_q == ST_RUN);
  // A reload request empties the FIFO, but a byte arriving alongside it is kept.
  assign flush     = run & done_fall;
  assign push      = ld_valid & ~full & ((state_q == ST_LOAD) | flush);
  assign pop       = slot & ~empty & ((state_q == ST_LOAD) | (state_q == ST_DRAIN));
  assign wr_idx    = flush ? '0 : wr_ptr_q;

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_d + 1'b1;
      count_d  = count_d + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_d - 1'b1;
    end
    overflow_d  = overflow_q | ((state_q == ST_LOAD) & ld_valid & full);
    // The write window always closes on a slot edge, so a new launch can follow back to back.
    wr_active_d = slot ? pop : wr_active_q;
    wr_addr_d   = pop ? fifo_addr_q[rd_ptr_q] : wr_addr_q;
    wr_data_d   = pop ? fifo_data_q[rd_ptr_q] : wr_data_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_LOAD;
      ST_LOAD:  if (ld_done) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (done_fall)           state_d = ST_LOAD;
        else if (slot && empty)  state_d = ST_RUN;
      end
      ST_RUN:   if (done_fall) state_d = ST_LOAD;
      default:  state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_RESET;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      wr_active_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      done_q      <= ld_done;
      wr_active_q <= wr_active_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr_q[wr_idx] <= ld_addr;
      fifo_data_q[wr_idx] <= ld_data;
    end
  end

  // RUN hands the port straight to the NES with no added latency.
  assign mem_addr  = run ? {{(25-ADDR_W){1'b0}}, nes_addr} : {{(25-ADDR_W){1'b0}}, wr_addr_q};
  assign mem_we    = run ? nes_wr : wr_active_q;
  assign mem_din   = run ? nes_dout : wr_data_q;
  assign mem_oe_a  = run & nes_rd_cpu;
  assign mem_oe_b  = run & nes_rd_ppu;
  assign sd_drive  = run ? nes_wr : wr_active_q;
  assign nes_reset = ~run;
  assign fifo_full = full;
  assign overflow  = overflow_q;
  assign state     = state_q;

endmodule
